// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. It takes one input bit per clock, MSB first,
// and saturates the result to all nines when the value does not fit in DIGITS digits.
//
// state | meaning
// IDLE  | waiting for a request; in_rdy=1
// CONV  | one double-dabble step per clock; cnt_q holds the bits still to process
// DONE  | result presented on bcd/ovf until out_rdy
module binary_to_bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [WIDTH-1:0]      in,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, adj;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  // Add-3 correction on every digit >= 5 before the shift.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          state_d = CONV;
          acc_d   = '0;
          sh_d    = in;
          cnt_d   = CW'(WIDTH);
          ovf_d   = 1'b0;
        end
      end
      CONV: begin
        // The bit leaving the top digit marks a value that does not fit.
        acc_d = {adj[AW-2:0], sh_q[WIDTH-1]};
        ovf_d = ovf_q | adj[AW-1];
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_rdy  = (state_q == IDLE);
  assign out_val = (state_q == DONE);
  assign ovf     = (state_q == DONE) && ovf_q;
  assign bcd     = (state_q != DONE) ? '0 :
                   ovf_q             ? {DIGITS{4'h9}} : acc_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: three instances (5b/2d, 8b/2d, 8b/3d) checked against an
// arithmetic decimal model, covering latency, backpressure, saturation and reset behaviour.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_val;
  logic [7:0]  din;
  logic        out_rdy;
  logic [2:0]  rdy_v, val_v, ovf_v;
  logic [7:0]  bcd0, bcd1;
  logic [11:0] bcd2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.WIDTH(5), .DIGITS(2)) u_w5d2 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val[0]), .in_rdy(rdy_v[0]), .in(din[4:0]),
    .out_val(val_v[0]), .out_rdy(out_rdy), .bcd(bcd0), .ovf(ovf_v[0]));

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_w8d2 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val[1]), .in_rdy(rdy_v[1]), .in(din),
    .out_val(val_v[1]), .out_rdy(out_rdy), .bcd(bcd1), .ovf(ovf_v[1]));

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_w8d3 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val[2]), .in_rdy(rdy_v[2]), .in(din),
    .out_val(val_v[2]), .out_rdy(out_rdy), .bcd(bcd2), .ovf(ovf_v[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic get(input int w, output logic r, output logic v, output logic [11:0] b,
                     output logic o);
    r = rdy_v[w];
    v = val_v[w];
    o = ovf_v[w];
    case (w)
      0:       b = {4'h0, bcd0};
      1:       b = {4'h0, bcd1};
      default: b = bcd2;
    endcase
  endtask

  // Decimal digits of v, or all nines with overflow when v needs more than d digits.
  function automatic logic [11:0] ref_bcd(input int v, input int d, output logic o);
    logic [11:0] r;
    int lim, t;
    r   = '0;
    lim = 1;
    t   = v;
    for (int k = 0; k < d; k++) lim = lim * 10;
    o = (v >= lim);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = o ? 4'h9 : 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check_idle(input string tag, input int w);
    logic r, v, o;
    logic [11:0] b;
    get(w, r, v, b, o);
    chk({tag, "_rdy"}, 32'(r), 32'd1);
    chk({tag, "_val"}, 32'(v), 32'd0);
    chk({tag, "_bcd"}, 32'(b), 32'd0);
    chk({tag, "_ovf"}, 32'(o), 32'd0);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_conv(input int w, input int val, input int hold, input bit noise,
                         input bit glitch);
    int width, digits;
    logic r, v, o, eo;
    logic [11:0] b, eb;
    bit ok;
    width  = (w == 0) ? 5 : 8;
    digits = (w == 2) ? 3 : 2;
    eb = ref_bcd(val, digits, eo);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      get(w, r, v, b, o);
      if (r) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("wait_idle", 32'(ok), 32'd1);
    din       = val[7:0];
    in_val[w] = 1'b1;
    out_rdy   = (hold == 0);
    @(posedge clk); #1;
    in_val[w] = 1'b0;
    get(w, r, v, b, o);
    chk("accept_rdy", 32'(r), 32'd0);
    for (int c = 1; c <= width; c++) begin
      @(posedge clk); #1;
      get(w, r, v, b, o);
      chk("latency_val", 32'(v), 32'(c == width));
      if (c < width) begin
        chk("conv_bcd", 32'(b), 32'd0);
        chk("conv_ovf", 32'(o), 32'd0);
      end
      if (noise) begin
        in_val[w] = 1'($urandom_range(0, 1));
        din       = 8'($urandom);
      end
      if (glitch && c == 2) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    chk("done_bcd", 32'(b), 32'(eb));
    chk("done_ovf", 32'(o), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      get(w, r, v, b, o);
      chk("hold_val", 32'(v), 32'd1);
      chk("hold_rdy", 32'(r), 32'd0);
      chk("hold_bcd", 32'(b), 32'(eb));
      chk("hold_ovf", 32'(o), 32'(eo));
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_val[w] = 1'b0;
    check_idle("release", w);
    if (noise) begin
      @(posedge clk); #1;
      get(w, r, v, b, o);
      chk("no_extra_conv", 32'(r), 32'd1);
    end
  endtask

  initial begin
    logic r, v, o;
    logic [11:0] b;
    rst_n   = 1'b0;
    in_val  = '0;
    din     = '0;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int w = 0; w < 3; w++) check_idle("reset", w);

    for (int i = 0; i < 32; i++) do_conv(0, i, 0, 1'b0, 1'b0);
    do_conv(0, 27, 4, 1'b0, 1'b0);

    do_conv(1, 99, 0, 1'b0, 1'b0);
    do_conv(1, 100, 1, 1'b0, 1'b0);
    do_conv(1, 255, 0, 1'b0, 1'b0);
    do_conv(2, 255, 0, 1'b0, 1'b0);
    do_conv(2, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      do_conv(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      do_conv(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    do_conv(0, 12, 0, 1'b1, 1'b0);
    do_conv(0, 19, 2, 1'b0, 1'b1);

    // Reset in the middle of converting 31 discards it.
    din       = 8'd31;
    in_val[0] = 1'b1;
    @(posedge clk); #1;
    in_val[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("midconv_reset", 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      get(0, r, v, b, o);
      chk("discard_val", 32'(v), 32'd0);
    end
    do_conv(0, 7, 0, 1'b0, 1'b0);

    // Reset wins over a handshake on the same edge.
    din       = 8'd5;
    in_val[0] = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    in_val[0] = 1'b0;
    rst_n     = 1'b1;
    check_idle("reset_vs_accept", 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      get(0, r, v, b, o);
      chk("no_accept_rdy", 32'(r), 32'd1);
      chk("no_accept_val", 32'(v), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
- REQ-001: Parameter WIDTH, default 5: binary input width, legal range 1..32.
- REQ-002: Parameter DIGITS, default 2: number of BCD output digits, legal range 1..10.
- REQ-003: clk  input  1: single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1: reset, synchronous and active-low.
- REQ-005: in_val  input  1: request valid.
- REQ-006: in_rdy  output  1: block can accept a request.
- REQ-007: in  input  WIDTH: unsigned binary value to convert.
- REQ-008: out_val  output  1: result valid.
- REQ-009: out_rdy  input  1: consumer accepts the result.
- REQ-010: bcd  output  4*DIGITS: packed BCD result; digit k occupies bits [4k+3:4k], digit 0 is the ones digit.
- REQ-011: ovf  output  1: input value exceeds 10^DIGITS-1.

Function
- REQ-012: FSM states SHALL be IDLE, CONV and DONE, with IDLE as the reset state.
- REQ-013: in_rdy SHALL equal (state==IDLE), and out_val SHALL equal (state==DONE); both are registered-state decodes with no combinational path from any input.
- REQ-014: IDLE to CONV SHALL occur on an edge with in_val&in_rdy: latch in, clear the BCD accumulator and ovf, and load bit counter = WIDTH.
- REQ-015: Each CONV edge SHALL perform one double-dabble step, processing input bits MSB first.
  - First, add 3 to every accumulator digit that is >=5.
  - Then shift left {accumulator, remaining input} by 1.
  - Then decrement the counter.
- REQ-016: The bit shifted out of the top accumulator digit on each step SHALL be OR-ed into a sticky ovf register.
- REQ-017: CONV to DONE SHALL occur on the edge that processes the last bit (counter 1 to 0). out_val SHALL rise exactly WIDTH cycles after the accept edge, for a fixed latency of WIDTH clocks.
- REQ-018: In DONE, if ovf=1, bcd SHALL present all digits = 9 (saturate); otherwise bcd SHALL present the accumulator.
- REQ-019: bcd and ovf SHALL remain stable while out_val=1 and out_rdy=0, for any number of cycles.
- REQ-020: DONE to IDLE SHALL occur on an edge with out_val&out_rdy. in_rdy SHALL rise the following cycle, giving a minimum issue interval of WIDTH+2 cycles.
- REQ-021: in_val SHALL be ignored in CONV and DONE: no capture, no effect on the conversion in progress.
- REQ-022: out_rdy SHALL be ignored in IDLE and CONV.
- REQ-023: Outside DONE, bcd SHALL read 0 and ovf SHALL read 0.
- REQ-024: Every digit of bcd SHALL be in range 0..9 at all times.
- REQ-025: Input 0 SHALL produce bcd=0 and ovf=0 with the normal WIDTH-cycle latency; there is no early exit.
- REQ-026: When 10^DIGITS > 2^WIDTH-1, ovf SHALL never assert.

Reset
- REQ-027: On any edge with rst_n=0, the block SHALL go to state IDLE, with accumulator=0, counter=0 and ovf=0.
  - Outputs the cycle after: in_rdy=1, out_val=0, bcd=0, ovf=0.
- REQ-028: Reset SHALL override all other inputs, including a handshake on the same edge. A conversion or pending result interrupted by reset SHALL be discarded, never presented.
- REQ-029: There SHALL be no asynchronous path from rst_n; a rst_n pulse between edges has no effect.

Verification
- REQ-030: WIDTH=5, DIGITS=2, exhaustive input 0..31 with out_rdy=1 -> bcd = decimal value of the input (e.g. 31 -> 0x31, 19 -> 0x19, 10 -> 0x10), ovf=0, out_val exactly 5 cycles after each accept.
- REQ-031: WIDTH=5, DIGITS=2, in=27, out_rdy held 0 for 4 cycles after out_val rises -> bcd=0x27 stable throughout, in_rdy=0. out_rdy=1 -> in_rdy=1 the next cycle.
- REQ-032: WIDTH=8, DIGITS=2: in=99 -> bcd=0x99, ovf=0; in=100 -> bcd=0x99, ovf=1; in=255 -> bcd=0x99, ovf=1.
- REQ-033: WIDTH=8, DIGITS=3, in=255 -> bcd=0x255 after 8 cycles; in=0 -> bcd=0x000 after 8 cycles.
- REQ-034: WIDTH=5, DIGITS=2, rst_n=0 for one edge at CONV cycle 3 of in=31 -> outputs match REQ-027 the next cycle, out_val never asserts for 31. A subsequent in=7 -> bcd=0x07.
- REQ-035: WIDTH=5, DIGITS=2, in_val toggled with varying in during CONV/DONE of in=12 -> result 0x12, and no extra conversion starts.
